// File: rtl/muldiv_ctrl_if.sv
// Pipeline-side bundle for muldiv_ctrl: request, flush, MTHI/MTLO writes, and HI/LO/status back.
// The pipeline drives through the master modport; the sequencer uses slave.
interface muldiv_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        flush;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, opA, opB, flush, we_hi, we_lo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, opA, opB, flush, we_hi, we_lo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative 32-step multiply / restoring-divide sequencer owning the HI/LO registers.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV (op[1]); otherwise op[1] is ignored.
module muldiv_ctrl (
    input  logic                clk,
    input  logic                reset,
    muldiv_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opd_q, opd_d;     // multiplicand or divisor magnitude
    logic        is_div_q, is_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] sum33, rem33, diff33;
    logic        rem_ge;
    logic [63:0] mul_next, div_next, step_next, res;

`ifdef MULDIV_SIGNED_EN
    logic        neg_res_q, neg_res_d;  // negate product / quotient
    logic        neg_rem_q, neg_rem_d;  // negate remainder (follows dividend)
    logic        sgn_op;

    assign sgn_op = bus.op[1];
    assign mag_a  = (sgn_op && bus.opA[31]) ? -bus.opA : bus.opA;
    assign mag_b  = (sgn_op && bus.opB[31]) ? -bus.opB : bus.opB;
`else
    logic        unused_op1;

    assign unused_op1 = bus.op[1];
    assign mag_a      = bus.opA;
    assign mag_b      = bus.opB;
`endif

    // One iteration of either algorithm, computed from the current accumulator.
    always_comb begin
        sum33     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
        mul_next  = {sum33, acc_q[31:1]};
        rem33     = acc_q[63:31];
        rem_ge    = (rem33 >= {1'b0, opd_q});
        diff33    = rem33 - {1'b0, opd_q};
        div_next  = rem_ge ? {diff33[31:0], acc_q[30:0], 1'b1}
                           : {rem33[31:0],  acc_q[30:0], 1'b0};
        step_next = is_div_q ? div_next : mul_next;
    end

    always_comb begin
        res = step_next;
`ifdef MULDIV_SIGNED_EN
        if (is_div_q) begin
            if (neg_res_q) res[31:0]  = -step_next[31:0];
            if (neg_rem_q) res[63:32] = -step_next[63:32];
        end else if (neg_res_q) begin
            res = -step_next;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif
        unique case (state_q)
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                    count_d = 5'd0;
                end else begin
                    acc_d   = step_next;
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        hi_d    = res[63:32];
                        lo_d    = res[31:0];
                        state_d = S_DONE;
                    end
                end
            end
            default: begin  // S_IDLE, S_DONE: not busy, accept writes and new requests
                state_d = S_IDLE;
                if (bus.we_hi) hi_d = bus.wdata;
                if (bus.we_lo) lo_d = bus.wdata;
                if (bus.start) begin
                    if (bus.op[0] && (bus.opB == 32'd0)) begin
                        // Divide by zero: fixed result, no iterations.
                        hi_d    = bus.opA;
                        lo_d    = 32'hFFFF_FFFF;
                        state_d = S_DONE;
                    end else begin
                        is_div_d = bus.op[0];
                        opd_d    = bus.op[0] ? mag_b : mag_a;
                        acc_d    = {32'd0, (bus.op[0] ? mag_a : mag_b)};
                        count_d  = 5'd0;
                        state_d  = S_RUN;
`ifdef MULDIV_SIGNED_EN
                        neg_res_d = sgn_op & (bus.opA[31] ^ bus.opB[31]);
                        neg_rem_d = sgn_op & bus.opA[31];
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= 5'd0;
            acc_q    <= 64'd0;
            opd_q    <= 32'd0;
            is_div_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO queued at issue, popped on each done.
module tb_muldiv_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t exp_q[$];

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Advance one cycle; single-cycle request pulses drop at every edge.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.hi = h;
        e.lo = l;
        exp_q.push_back(e);
    endtask

    // Cycles 1..n after issue: busy expected for 1..b_hi, done only at d_at.
    // ms_at >= 1 pulses a stray start at that cycle, which must be ignored.
    task automatic watch(input int n, input int d_at, input int b_hi, input int ms_at);
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == ms_at) issue(2'b01, 32'd1, 32'd1);
            chk($sformatf("busy@%0d", k), {31'd0, bus.busy}, {31'd0, (k <= b_hi)});
            chk($sformatf("done@%0d", k), {31'd0, bus.done}, {31'd0, (k == d_at)});
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: hi=%h lo=%h with empty queue", bus.hi, bus.lo);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_hi", bus.hi, e.hi);
                chk("sb_lo", bus.lo, e.lo);
            end
        end
    end

    logic [31:0] last_lo;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.we_hi = 1'b0; bus.we_lo = 1'b0;
        bus.op = 2'b00; bus.opA = 32'd0; bus.opB = 32'd0; bus.wdata = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);

        // MULTU max x max
        tick();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push(32'hFFFF_FFFE, 32'h0000_0001);
        watch(34, 33, 32, -1);

        // DIVU 100/7 with a stray start mid-run
        tick();
        issue(2'b01, 32'd100, 32'd7);
        push(32'd2, 32'd14);
        watch(34, 33, 32, 5);

        // DIVU 5/0: immediate DONE, never busy
        tick();
        issue(2'b01, 32'd5, 32'd0);
        push(32'd5, 32'hFFFF_FFFF);
        watch(3, 1, 0, -1);

        // MULT -3 x 7
        tick();
        issue(2'b10, 32'hFFFF_FFFD, 32'd7);
`ifdef MULDIV_SIGNED_EN
        push(32'hFFFF_FFFF, 32'hFFFF_FFEB);
`else
        push(32'h0000_0006, 32'hFFFF_FFEB);
`endif
        watch(34, 33, 32, -1);

        // DIV -7 / 2
        tick();
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
`ifdef MULDIV_SIGNED_EN
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        push(32'h0000_0001, 32'h7FFF_FFFC);
`endif
        watch(34, 33, 32, -1);

        // DIV 0x80000000 / -1
        tick();
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
`ifdef MULDIV_SIGNED_EN
        push(32'h0000_0000, 32'h8000_0000);
        last_lo = 32'h8000_0000;
`else
        push(32'h8000_0000, 32'h0000_0000);
        last_lo = 32'h0000_0000;
`endif
        watch(34, 33, 32, -1);

        // MTHI preload, then flushed MULTU with an ignored MTLO while busy
        tick();
        bus.we_hi = 1'b1;
        bus.wdata = 32'h0000_AAAA;
        tick();
        chk("mthi", bus.hi, 32'h0000_AAAA);
        issue(2'b00, 32'd3, 32'd4);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 5) begin
                bus.we_lo = 1'b1;
                bus.wdata = 32'h0000_1234;
            end
            if (k == 10) bus.flush = 1'b1;
            if (k == 9 || k == 10 || k == 11 || k == 12)
                chk($sformatf("flush_busy@%0d", k), {31'd0, bus.busy}, {31'd0, (k <= 10)});
            if (k == 33) chk("flush_nodone", {31'd0, bus.done}, 32'd0);
        end
        chk("flush_hi", bus.hi, 32'h0000_AAAA);
        chk("flush_lo", bus.lo, last_lo);

        // Back-to-back: MULTU 2x3, then DIVU 9/2 accepted in DONE
        tick();
        issue(2'b00, 32'd2, 32'd3);
        push(32'd0, 32'd6);
        for (int k = 1; k <= 68; k++) begin
            tick();
            if (k == 33) begin
                issue(2'b01, 32'd9, 32'd2);
                push(32'd1, 32'd4);
            end
            chk($sformatf("b2b_busy@%0d", k), {31'd0, bus.busy},
                {31'd0, ((k <= 32) || (k >= 34 && k <= 65))});
            chk($sformatf("b2b_done@%0d", k), {31'd0, bus.done},
                {31'd0, (k == 33 || k == 66)});
        end

        // Reset in the middle of a run
        tick();
        issue(2'b00, 32'd5, 32'd5);
        for (int k = 1; k <= 10; k++) tick();
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_hi", bus.hi, 32'd0);
        chk("mid_rst_lo", bus.lo, 32'd0);
        for (int k = 1; k <= 40; k++) tick();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
